// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_adder_comb.sv
// One-bit full adder; the single datapath cell stepped across all bit positions.
module full_adder_comb (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic cout,
  output logic sum
);

  // Plain sum/majority equations
  always_comb begin
    sum  = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: accepts operands, steps one shared full adder
// LSB-first one bit per clock, then holds sum/cout/ovf until consumed.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   a_sr_q,      a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,      b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q,    sum_sr_d;
  logic               carry_q,     carry_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               cout_q,      cout_d;
  logic               ovf_q,       ovf_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q,      busy_d;

  logic fa_sum;
  logic fa_cout;

  // Shared one-bit datapath, fed from the operand LSBs and the carry flop
  full_adder_comb u_fa (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .cin  (carry_q),
    .cout (fa_cout),
    .sum  (fa_sum)
  );

  // Next-state, datapath stepping and handshake decode
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    count_d  = count_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = fa_cout;
        count_d  = count_q + CNT_W'(1);
        // MSB step: carry_q is the carry into the MSB here
        if (count_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake flags follow the next state so they are flops, not input paths
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_RUN) || (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      sum_sr_q    <= sum_sr_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_sr_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed table at WIDTH=8, handshake corner
// sequences, and random streams at WIDTH=8, 2 and 16.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared operand bus; each DUT sees the low bits it needs
  logic [31:0] a_v = '0;
  logic [31:0] b_v = '0;
  logic        cin_v = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_oready = 1'b1;
  int          sel = 8;

  logic        iv8, iv2, iv16;
  logic        or8, or2, or16;
  logic        ir8, ir2, ir16;
  logic        ov8, ov2, ov16;
  logic        co8, co2, co16;
  logic        of8, of2, of16;
  logic        bz8, bz2, bz16;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [15:0] sum16;

  assign iv8  = (sel == 8)  && s_valid;
  assign iv2  = (sel == 2)  && s_valid;
  assign iv16 = (sel == 16) && s_valid;
  assign or8  = (sel == 8)  ? s_oready : 1'b1;
  assign or2  = (sel == 2)  ? s_oready : 1'b1;
  assign or16 = (sel == 16) ? s_oready : 1'b1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin_v),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(co8), .ovf(of8), .busy(bz8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
    .a(a_v[1:0]), .b(b_v[1:0]), .cin(cin_v),
    .out_valid(ov2), .out_ready(or2), .sum(sum2), .cout(co2), .ovf(of2), .busy(bz2)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a_v[15:0]), .b(b_v[15:0]), .cin(cin_v),
    .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(co16), .ovf(of16), .busy(bz16)
  );

  // View of the DUT currently under test
  logic [31:0] cur_sum;
  logic        cur_ready, cur_valid, cur_cout, cur_ovf, cur_busy;
  always_comb begin
    cur_sum = '0; cur_ready = 1'b0; cur_valid = 1'b0;
    cur_cout = 1'b0; cur_ovf = 1'b0; cur_busy = 1'b0;
    case (sel)
      2: begin
        cur_sum = 32'(sum2); cur_ready = ir2; cur_valid = ov2;
        cur_cout = co2; cur_ovf = of2; cur_busy = bz2;
      end
      16: begin
        cur_sum = 32'(sum16); cur_ready = ir16; cur_valid = ov16;
        cur_cout = co16; cur_ovf = of16; cur_busy = bz16;
      end
      default: begin
        cur_sum = 32'(sum8); cur_ready = ir8; cur_valid = ov8;
        cur_cout = co8; cur_ovf = of8; cur_busy = bz8;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;
  int val_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, wait for in_ready, pass the acceptance edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input bit hold_valid);
    int k;
    @(negedge clk);
    a_v = a; b_v = b; cin_v = c; s_valid = 1'b1;
    k = 0;
    while (!cur_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (!cur_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold_valid) s_valid = 1'b0;
  endtask

  // Advance to the next negedge with out_valid high, bounded
  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (cur_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("valid_timeout", 64'd0, 64'd1);
    else val_cyc = cyc;
  endtask

  function automatic logic ref_ovf(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic [63:0] s);
    return (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction

  // Back-to-back random operands with both handshakes held high
  task automatic stream(input int w, input int n);
    logic [63:0] mask, full;
    logic [31:0] ra, rb;
    logic        rc;
    bit          ok;
    int          last;
    mask = (64'd1 << w) - 64'd1;
    last = 0;
    sel = w;
    s_oready = 1'b1;
    @(negedge clk);
    ra = $urandom & 32'(mask); rb = $urandom & 32'(mask); rc = 1'($urandom);
    a_v = ra; b_v = rb; cin_v = rc; s_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_valid(4 * w + 16, ok);
      if (!ok) break;
      full = 64'(ra) + 64'(rb) + 64'(rc);
      check($sformatf("w%0d_sum_%0d", w, i), 64'(cur_sum), full & mask);
      check($sformatf("w%0d_cout_%0d", w, i), 64'(cur_cout), 64'(full[w]));
      check($sformatf("w%0d_ovf_%0d", w, i), 64'(cur_ovf),
            64'(ref_ovf(w, 64'(ra), 64'(rb), full)));
      if (i > 0) check($sformatf("w%0d_period_%0d", w, i), 64'(val_cyc - last), 64'(w + 2));
      last = val_cyc;
      ra = $urandom & 32'(mask); rb = $urandom & 32'(mask); rc = 1'($urandom);
      a_v = ra; b_v = rb; cin_v = rc;
    end
    s_valid = 1'b0;
    repeat (w + 4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    bit seen;

    tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(ir8), 64'd1);
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_busy", 64'(bz8), 64'd0);
    check("rst_sum", 64'(sum8), 64'h00);
    check("rst_cout", 64'(co8), 64'd0);
    check("rst_ovf", 64'(of8), 64'd0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      start_op(32'(tbl[i].a), 32'(tbl[i].b), tbl[i].cin, 1'b0);
      wait_valid(40, ok);
      if (ok) begin
        check($sformatf("tbl%0d_latency", i), 64'(val_cyc - acc_cyc), 64'd8);
        check($sformatf("tbl%0d_sum", i), 64'(sum8), 64'(tbl[i].s));
        check($sformatf("tbl%0d_cout", i), 64'(co8), 64'(tbl[i].co));
        check($sformatf("tbl%0d_ovf", i), 64'(of8), 64'(tbl[i].ov));
        check($sformatf("tbl%0d_busy", i), 64'(bz8), 64'd1);
      end
      @(negedge clk);
    end

    // Backpressure in DONE with new operands pending
    s_oready = 1'b0;
    start_op(32'h12, 32'h34, 1'b0, 1'b0);
    wait_valid(40, ok);
    check("bp_first_sum", 64'(sum8), 64'h46);
    a_v = 32'hAA; b_v = 32'h11; cin_v = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_%0d", k),
            {52'd0, ov8, ir8, co8, of8, sum8}, {52'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h46});
    end
    s_oready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", {62'd0, ir8, ov8}, {62'd0, 1'b1, 1'b0});
    check("bp_release_sum_hold", 64'(sum8), 64'h46);
    @(negedge clk);
    acc_cyc = cyc;
    check("bp_pending_accepted", {62'd0, bz8, ir8}, {62'd0, 1'b1, 1'b0});
    s_valid = 1'b0;
    wait_valid(40, ok);
    check("bp_second_sum", 64'(sum8), 64'hBC);
    check("bp_second_flags", {62'd0, co8, of8}, 64'd0);
    @(negedge clk);

    // Abort by reset at count 3
    start_op(32'h0F, 32'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_idle", {61'd0, ir8, bz8, ov8}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("abort_sum", 64'(sum8), 64'h00);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ov8) seen = 1'b1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    start_op(32'h10, 32'h20, 1'b0, 1'b0);
    wait_valid(40, ok);
    check("after_abort_sum", 64'(sum8), 64'h30);
    @(negedge clk);

    // Streams at three widths
    stream(8, 200);
    stream(2, 200);
    stream(16, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on run time
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
